// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Each
// transaction runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
// Data has priority, but IF is granted once after MAX_CONSEC back-to-back
// data grants taken while IF was waiting.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_CONSEC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall,
  output logic            busy
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int KW = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] LAT_LAST   = CW'(MEM_LAT - 1);
  localparam logic [KW-1:0] CONSEC_MAX = KW'(MAX_CONSEC);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_IF} owner_t;

  state_t        state;
  state_t        state_nxt;
  owner_t        owner;
  logic [CW-1:0] lat_cnt;
  logic [KW-1:0] consec;
  logic          grant_d;
  logic          grant_i;
  logic          lat_done;

  // Data wins unless IF has already been passed over MAX_CONSEC times.
  assign grant_d  = d_req && (!if_req || (consec < CONSEC_MAX));
  assign grant_i  = if_req && !grant_d;
  assign lat_done = (lat_cnt == LAT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: requests are only looked at while IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_d || grant_i) state_nxt = S_ACCESS;
      S_ACCESS: if (lat_done) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Grant capture, latency counting, read-data capture and port release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      lat_cnt   <= '0;
      consec    <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          lat_cnt <= '0;
          if (grant_d) begin
            owner     <= OWN_DATA;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            consec    <= if_req ? consec + 1'b1 : '0;
          end else if (grant_i) begin
            owner     <= OWN_IF;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            consec    <= '0;
          end
        end
        S_ACCESS: begin
          if (lat_done) begin
            lat_cnt <= '0;
            // Read data is only valid in the last access cycle.
            if (!mem_we) begin
              if (owner == OWN_IF) if_rdata <= mem_rdata;
              else                 d_rdata  <= mem_rdata;
            end
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_RESP:  owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  assign mem_en = (state == S_ACCESS) && (lat_cnt == '0);
  assign if_ack = (state == S_RESP) && (owner == OWN_IF);
  assign d_ack  = (state == S_RESP) && (owner == OWN_DATA);
  assign busy   = (state != S_IDLE);
  // Forced low during reset so the sequencer is never frozen by an aborted access.
  assign stall  = !rst && ((d_req && !d_ack) || (if_req && !if_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus an
// ack-driven scoreboard, directed scenarios and randomized requesters.
`timescale 1ns/100ps
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2, MAXC = 4;
  localparam int W_IFACK = 0, W_DACK = 1, W_IFGNT = 2, W_DGNT = 3, W_ANY = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall, busy;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [3:0] d_be, mem_be;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t exp_q[$];
  bit   grant_log[$];
  int   n_chk = 0, n_fail = 0, n_acks = 0;

  // Reference model state: one transaction in flight, k = cycles since grant.
  txn_t        cur;
  bit          act = 0;
  int          k = 0, consec_m = 0;
  logic [31:0] m_if_rd = '0, m_d_rd = '0;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_cycle();
    logic e_en, e_we, e_ifa, e_da, e_busy, e_stall;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wd;
    e_en = 0; e_we = 0; e_ifa = 0; e_da = 0; e_busy = 0; e_stall = 0;
    e_be = '0; e_addr = '0; e_wd = '0;
    mem_rdata = $urandom;
    if (rst) begin
      act = 0; consec_m = 0; m_if_rd = '0; m_d_rd = '0;
      exp_q.delete();
    end else begin
      if (act) begin
        k++;
        e_busy = 1;
        if (k <= LAT) begin
          e_en = (k == 1); e_we = cur.we; e_be = cur.be; e_addr = cur.addr; e_wd = cur.wdata;
          if (k == LAT) mem_rdata = mem_f(cur.addr);
        end else begin
          if (cur.is_if) begin e_ifa = 1; m_if_rd = mem_f(cur.addr); end
          else begin e_da = 1; if (!cur.we) m_d_rd = mem_f(cur.addr); end
          act = 0;
        end
      end else if (d_req && (!if_req || consec_m < MAXC)) begin
        cur.is_if = 0; cur.addr = d_addr; cur.we = d_we; cur.be = d_be; cur.wdata = d_wdata;
        cur.exp_rd = d_we ? m_d_rd : mem_f(d_addr);
        consec_m = if_req ? consec_m + 1 : 0;
        act = 1; k = 0;
        exp_q.push_back(cur);
      end else if (if_req) begin
        cur.is_if = 1; cur.addr = if_addr; cur.we = 0; cur.be = '0; cur.wdata = '0;
        cur.exp_rd = mem_f(if_addr);
        consec_m = 0;
        act = 1; k = 0;
        exp_q.push_back(cur);
      end
      e_stall = (d_req && !e_da) || (if_req && !e_ifa);
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_be", mem_be, e_be);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_ack", if_ack, e_ifa);
    chk("d_ack", d_ack, e_da);
    chk("busy", busy, e_busy);
    chk("stall", stall, e_stall);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata", d_rdata, m_d_rd);
  endtask

  // Reference model: evaluated mid low-phase, drives mem_rdata for the next edge.
  initial begin
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      model_cycle();
    end
  end

  // Scoreboard monitor: pops the expected response whenever an ack appears.
  initial begin
    txn_t r;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && (if_ack || d_ack)) begin
        chk("ack_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("ack_owner", if_ack, r.is_if);
          if (r.is_if) chk("sb_if_rdata", if_rdata, r.exp_rd);
          else         chk("sb_d_rdata", d_rdata, r.exp_rd);
          grant_log.push_back(r.is_if);
        end
        n_acks++;
      end
    end
  end

  task automatic wait_for(input int what, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      case (what)
        W_IFACK: ok = if_ack;
        W_DACK:  ok = d_ack;
        W_IFGNT: ok = mem_en && (mem_be == 4'h0);
        W_DGNT:  ok = mem_en && (mem_be != 4'h0);
        default: ok = if_ack || d_ack;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_timeout: event %0d not seen within 60 cycles at %0t", what, $time);
    end
  endtask

  task automatic drive_if(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if_addr = $urandom & 32'h0000_FFFC;
      if_req  = 1;
      if ($urandom_range(0, 3) == 0) begin
        wait_for(W_IFGNT, ok);
        if_req = 0;
        wait_for(W_IFACK, ok);
      end else begin
        wait_for(W_IFACK, ok);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        if_req = 0;
      end
    end
  endtask

  task automatic drive_d(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = $urandom & 32'h0000_FFFC;
      d_wdata = $urandom;
      d_be    = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
      d_req   = 1;
      if ($urandom_range(0, 3) == 0) begin
        wait_for(W_DGNT, ok);
        d_req = 0;
        wait_for(W_DACK, ok);
      end else begin
        wait_for(W_DACK, ok);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        d_req = 0;
      end
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int a0;
    bit exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    #1 rst = 0;

    // IF read alone
    @(negedge clk);
    if_addr = 32'h100; if_req = 1;
    wait_for(W_IFACK, ok);
    if_req = 0;
    chk("if_read_0x100", if_rdata, 32'hDEADBEEF);

    // Data write leaves d_rdata untouched
    @(negedge clk);
    d_addr = 32'h40; d_be = 4'b0011; d_wdata = 32'h1234; d_we = 1; d_req = 1;
    wait_for(W_DGNT, ok);
    chk("wr_mem_be", mem_be, 4'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'h1234);
    wait_for(W_DACK, ok);
    d_req = 0; d_we = 0;
    chk("wr_d_rdata_kept", d_rdata, 32'h0);

    // Both requesters held: grant order D,D,D,D,I repeating
    repeat (2) @(negedge clk);
    grant_log.delete();
    d_we = 0; d_be = 4'hF; d_addr = 32'h80; if_addr = 32'h200;
    d_req = 1; if_req = 1;
    for (int i = 0; i < 10; i++) wait_for(W_ANY, ok);
    d_req = 0; if_req = 0;
    @(negedge clk);
    #4;
    chk("grant_count", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], exp_pat[i]);

    // Data request dropped mid-access still completes exactly once
    repeat (2) @(negedge clk);
    a0 = n_acks;
    d_we = 0; d_be = 4'hF; d_addr = 32'h44; d_req = 1;
    wait_for(W_DGNT, ok);
    d_req = 0;
    wait_for(W_DACK, ok);
    repeat (6) @(negedge clk);
    chk("single_ack_after_drop", n_acks - a0, 1);

    // Randomized concurrent requesters
    fork
      drive_if(30);
      drive_d(30);
    join

    // Async reset in the second access cycle of a write, IF pending
    repeat (2) @(negedge clk);
    d_we = 1; d_be = 4'hF; d_addr = 32'h60; d_wdata = 32'hCAFE0001; if_addr = 32'h300;
    d_req = 1; if_req = 1;
    wait_for(W_DGNT, ok);
    @(negedge clk);
    #4 rst = 1;
    #0.5;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst = 0; d_req = 0; d_we = 0;
    wait_for(W_IFACK, ok);
    if_req = 0;
    chk("if_after_reset", if_rdata, mem_f(32'h300));

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
